// File: rtl/pwm_cfg_pkg.sv
// Shared configuration for the PWM setpoint controller: widths, register
// map, reset values and the ramp state encoding.
package pwm_cfg_pkg;

    localparam int PWMWIDTH_DEF = 19;
    localparam int DSBITS_DEF   = 8;

    localparam logic [2:0] ADDR_TGT0   = 3'd0;
    localparam logic [2:0] ADDR_TGT1   = 3'd1;
    localparam logic [2:0] ADDR_TGT2   = 3'd2;
    localparam logic [2:0] ADDR_DS     = 3'd3;
    localparam logic [2:0] ADDR_COMMIT = 3'd4;
    localparam logic [2:0] ADDR_STEP0  = 3'd5;
    localparam logic [2:0] ADDR_STEP1  = 3'd6;
    localparam logic [2:0] ADDR_ABORT  = 3'd7;

    localparam logic [18:0] CMPA_RST = {16'hA000, 3'h5};
    localparam logic [7:0]  DS_RST   = 8'h12;

    typedef enum logic {
        IDLE = 1'b0,
        RAMP = 1'b1
    } state_t;

endpackage

// File: rtl/pwm_setpoint_ctrl.sv
// Register-programmed PWM compare setpoint with a rate-limited ramp that only
// updates the PWM outputs at period boundaries.
module pwm_setpoint_ctrl
    import pwm_cfg_pkg::*;
#(
    parameter int PWMWIDTH = PWMWIDTH_DEF,
    parameter int DSBITS   = DSBITS_DEF
) (
    input  logic                clk1d,
    input  logic                rst,
    input  logic [2:0]          regAddr,
    input  logic [7:0]          regData,
    input  logic                regDataValid,
    input  logic                period_strobe,
    output logic [PWMWIDTH-1:0] cmpA,
    output logic [DSBITS-1:0]   ds_fraction,
    output logic                dirty,
    output logic                busy
);

    localparam int DW = PWMWIDTH + 1;
    localparam int UW = PWMWIDTH - 16;

    state_t              state_reg;
    logic [PWMWIDTH-1:0] cmpa_reg;
    logic [PWMWIDTH-1:0] target_reg;
    logic [PWMWIDTH-1:0] scratch_tgt_reg;
    logic [DSBITS-1:0]   ds_frac_reg;
    logic [DSBITS-1:0]   pend_ds_reg;
    logic [DSBITS-1:0]   scratch_ds_reg;
    logic [15:0]         step_reg;
    logic                dirty_reg;

    logic                do_commit;
    logic                do_abort;
    logic                scratch_wr;
    logic [DW-1:0]       diff;
    logic [DW-1:0]       mag;
    logic                go_down;
    logic                reach;
    logic [PWMWIDTH-1:0] cmpa_stepped;

    assign do_commit  = regDataValid && (regAddr == ADDR_COMMIT);
    assign do_abort   = regDataValid && (regAddr == ADDR_ABORT);
    assign scratch_wr = regDataValid && !(regAddr == ADDR_COMMIT || regAddr == ADDR_ABORT);

    // Signed distance to target in one extra bit; a step at least as large as
    // the remaining distance (or a zero step) lands exactly on the target.
    assign diff         = {1'b0, target_reg} - {1'b0, cmpa_reg};
    assign go_down      = diff[DW-1];
    assign mag          = go_down ? (~diff + DW'(1)) : diff;
    assign reach        = (step_reg == 16'h0000) || (DW'(step_reg) >= mag);
    assign cmpa_stepped = go_down ? (cmpa_reg - PWMWIDTH'(step_reg))
                                  : (cmpa_reg + PWMWIDTH'(step_reg));

    always_ff @(posedge clk1d or posedge rst) begin
        if (rst) begin
            state_reg       <= IDLE;
            cmpa_reg        <= PWMWIDTH'(CMPA_RST);
            target_reg      <= PWMWIDTH'(CMPA_RST);
            scratch_tgt_reg <= PWMWIDTH'(CMPA_RST);
            ds_frac_reg     <= DSBITS'(DS_RST);
            pend_ds_reg     <= DSBITS'(DS_RST);
            scratch_ds_reg  <= DSBITS'(DS_RST);
            step_reg        <= 16'h0000;
            dirty_reg       <= 1'b0;
        end else begin
            if (regDataValid) begin
                unique case (regAddr)
                    ADDR_TGT0:  scratch_tgt_reg[7:0]          <= regData;
                    ADDR_TGT1:  scratch_tgt_reg[15:8]         <= regData;
                    ADDR_TGT2:  scratch_tgt_reg[PWMWIDTH-1:16] <= UW'(regData[2:0]);
                    ADDR_DS:    scratch_ds_reg                <= DSBITS'(regData);
                    ADDR_STEP0: step_reg[7:0]                 <= regData;
                    ADDR_STEP1: step_reg[15:8]                <= regData;
                    default: ;
                endcase
            end

            if (do_commit)
                dirty_reg <= 1'b0;
            else if (scratch_wr)
                dirty_reg <= 1'b1;

            unique case (state_reg)
                IDLE: begin
                    if (do_commit) begin
                        target_reg  <= scratch_tgt_reg;
                        pend_ds_reg <= scratch_ds_reg;
                        state_reg   <= RAMP;
                    end else if (do_abort) begin
                        pend_ds_reg <= ds_frac_reg;
                    end
                end
                RAMP: begin
                    if (do_abort) begin
                        pend_ds_reg <= ds_frac_reg;
                        state_reg   <= IDLE;
                    end else begin
                        // The strobe step uses the target held before any
                        // same-cycle commit; the commit simply retargets.
                        if (period_strobe) begin
                            if (reach) begin
                                cmpa_reg    <= target_reg;
                                ds_frac_reg <= pend_ds_reg;
                                if (!do_commit)
                                    state_reg <= IDLE;
                            end else begin
                                cmpa_reg <= cmpa_stepped;
                            end
                        end
                        if (do_commit) begin
                            target_reg  <= scratch_tgt_reg;
                            pend_ds_reg <= scratch_ds_reg;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign cmpA        = cmpa_reg;
    assign ds_fraction = ds_frac_reg;
    assign dirty       = dirty_reg;
    assign busy        = (state_reg == RAMP);

endmodule

// File: tb/tb_pwm_setpoint_ctrl.sv
// Directed vector bench for pwm_setpoint_ctrl: one cycle per table row,
// plus hand-written reset-mid-ramp sequence.
module tb_pwm_setpoint_ctrl;

    logic        clk1d = 1'b0;
    logic        rst;
    logic [2:0]  regAddr;
    logic [7:0]  regData;
    logic        regDataValid;
    logic        period_strobe;
    logic [18:0] cmpA;
    logic [7:0]  ds_fraction;
    logic        dirty;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    pwm_setpoint_ctrl #(.PWMWIDTH(19), .DSBITS(8)) dut (
        .clk1d         (clk1d),
        .rst           (rst),
        .regAddr       (regAddr),
        .regData       (regData),
        .regDataValid  (regDataValid),
        .period_strobe (period_strobe),
        .cmpA          (cmpA),
        .ds_fraction   (ds_fraction),
        .dirty         (dirty),
        .busy          (busy)
    );

    always #5 clk1d = ~clk1d;

    typedef struct {
        logic        wr;
        logic [2:0]  addr;
        logic [7:0]  data;
        logic        stb;
        logic [18:0] e_cmp;
        logic [7:0]  e_ds;
        logic        e_dirty;
        logic        e_busy;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic wr, input logic [2:0] addr, input logic [7:0] data,
                       input logic stb, input logic [18:0] e_cmp, input logic [7:0] e_ds,
                       input logic e_dirty, input logic e_busy);
        vec_t v;
        v.wr = wr; v.addr = addr; v.data = data; v.stb = stb;
        v.e_cmp = e_cmp; v.e_ds = e_ds; v.e_dirty = e_dirty; v.e_busy = e_busy;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [18:0] e_cmp, input logic [7:0] e_ds,
                           input logic e_dirty, input logic e_busy);
        chk({tag, ".cmpA"},  32'(cmpA),        32'(e_cmp));
        chk({tag, ".ds"},    32'(ds_fraction), 32'(e_ds));
        chk({tag, ".dirty"}, 32'(dirty),       32'(e_dirty));
        chk({tag, ".busy"},  32'(busy),        32'(e_busy));
        $display("%s: cmpA=%h ds=%h dirty=%0d busy=%0d", tag, cmpA, ds_fraction, dirty, busy);
    endtask

    // Drive one cycle of inputs at the falling edge, sample 1ns after the rising edge.
    task automatic cycle(input logic wr, input logic [2:0] addr, input logic [7:0] data,
                         input logic stb);
        @(negedge clk1d);
        regDataValid  = wr;
        regAddr       = addr;
        regData       = data;
        period_strobe = stb;
        @(posedge clk1d);
        #1;
        regDataValid  = 1'b0;
        period_strobe = 1'b0;
    endtask

    initial begin
        rst = 1'b1; regAddr = 3'd0; regData = 8'h00; regDataValid = 1'b0; period_strobe = 1'b0;

        // A: program target 50105, ds 34, step 40, commit and ramp
        add(1, 3'd0, 8'h05, 0, 19'h50005, 8'h12, 1, 0);
        add(1, 3'd1, 8'h01, 0, 19'h50005, 8'h12, 1, 0);
        add(1, 3'd2, 8'hFD, 0, 19'h50005, 8'h12, 1, 0);
        add(1, 3'd3, 8'h34, 0, 19'h50005, 8'h12, 1, 0);
        add(1, 3'd5, 8'h40, 0, 19'h50005, 8'h12, 1, 0);
        add(1, 3'd6, 8'h00, 0, 19'h50005, 8'h12, 1, 0);
        add(1, 3'd4, 8'hFF, 0, 19'h50005, 8'h12, 0, 1);
        add(0, 3'd0, 8'h00, 0, 19'h50005, 8'h12, 0, 1);
        add(0, 3'd0, 8'h00, 1, 19'h50045, 8'h12, 0, 1);
        add(0, 3'd0, 8'h00, 1, 19'h50085, 8'h12, 0, 1);
        add(0, 3'd0, 8'h00, 1, 19'h500C5, 8'h12, 0, 1);
        add(0, 3'd0, 8'h00, 1, 19'h50105, 8'h34, 0, 0);
        add(0, 3'd0, 8'h00, 1, 19'h50105, 8'h34, 0, 0);
        // B: ramp down, retarget at 50085 to 50000 without overshoot
        add(1, 3'd1, 8'h00, 0, 19'h50105, 8'h34, 1, 0);
        add(1, 3'd3, 8'h56, 0, 19'h50105, 8'h34, 1, 0);
        add(1, 3'd4, 8'h00, 0, 19'h50105, 8'h34, 0, 1);
        add(0, 3'd0, 8'h00, 1, 19'h500C5, 8'h34, 0, 1);
        add(0, 3'd0, 8'h00, 1, 19'h50085, 8'h34, 0, 1);
        add(1, 3'd0, 8'h00, 0, 19'h50085, 8'h34, 1, 1);
        add(1, 3'd4, 8'h00, 0, 19'h50085, 8'h34, 0, 1);
        add(0, 3'd0, 8'h00, 1, 19'h50045, 8'h34, 0, 1);
        add(0, 3'd0, 8'h00, 1, 19'h50005, 8'h34, 0, 1);
        add(0, 3'd0, 8'h00, 1, 19'h50000, 8'h56, 0, 0);
        // C: commit coincident with strobe uses the old target for that step
        add(1, 3'd0, 8'h80, 0, 19'h50000, 8'h56, 1, 0);
        add(1, 3'd4, 8'h00, 0, 19'h50000, 8'h56, 0, 1);
        add(0, 3'd0, 8'h00, 1, 19'h50040, 8'h56, 0, 1);
        add(1, 3'd0, 8'h00, 0, 19'h50040, 8'h56, 1, 1);
        add(1, 3'd4, 8'h00, 1, 19'h50080, 8'h56, 0, 1);
        add(0, 3'd0, 8'h00, 1, 19'h50040, 8'h56, 0, 1);
        add(0, 3'd0, 8'h00, 1, 19'h50000, 8'h56, 0, 0);
        // D: abort at 50085 freezes output, discards pending ds, keeps dirty
        add(1, 3'd0, 8'h05, 0, 19'h50000, 8'h56, 1, 0);
        add(1, 3'd1, 8'h01, 0, 19'h50000, 8'h56, 1, 0);
        add(1, 3'd5, 8'h85, 0, 19'h50000, 8'h56, 1, 0);
        add(1, 3'd3, 8'h77, 0, 19'h50000, 8'h56, 1, 0);
        add(1, 3'd4, 8'h00, 0, 19'h50000, 8'h56, 0, 1);
        add(0, 3'd0, 8'h00, 1, 19'h50085, 8'h56, 0, 1);
        add(1, 3'd7, 8'h00, 0, 19'h50085, 8'h56, 0, 0);
        add(0, 3'd0, 8'h00, 1, 19'h50085, 8'h56, 0, 0);
        add(1, 3'd3, 8'h99, 0, 19'h50085, 8'h56, 1, 0);
        add(1, 3'd7, 8'h00, 0, 19'h50085, 8'h56, 1, 0);
        // E: step 0 jumps to target 00010 on the next strobe only
        add(1, 3'd5, 8'h00, 0, 19'h50085, 8'h56, 1, 0);
        add(1, 3'd0, 8'h10, 0, 19'h50085, 8'h56, 1, 0);
        add(1, 3'd1, 8'h00, 0, 19'h50085, 8'h56, 1, 0);
        add(1, 3'd2, 8'h00, 0, 19'h50085, 8'h56, 1, 0);
        add(1, 3'd4, 8'h00, 0, 19'h50085, 8'h56, 0, 1);
        add(0, 3'd0, 8'h00, 0, 19'h50085, 8'h56, 0, 1);
        add(0, 3'd0, 8'h00, 1, 19'h00010, 8'h99, 0, 0);
        // F: commit to the current value applies ds at next strobe
        add(1, 3'd3, 8'hAB, 0, 19'h00010, 8'h99, 1, 0);
        add(1, 3'd4, 8'h00, 0, 19'h00010, 8'h99, 0, 1);
        add(0, 3'd0, 8'h00, 1, 19'h00010, 8'hAB, 0, 0);
        // G: commit with strobe in IDLE defers the first step one strobe
        add(1, 3'd0, 8'h20, 0, 19'h00010, 8'hAB, 1, 0);
        add(1, 3'd4, 8'h00, 1, 19'h00010, 8'hAB, 0, 1);
        add(0, 3'd0, 8'h00, 1, 19'h00020, 8'hAB, 0, 0);

        repeat (3) @(posedge clk1d);
        #1;
        chk_all("reset_held", 19'h50005, 8'h12, 0, 0);
        @(negedge clk1d);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            cycle(0, 3'd0, 8'h00, 1);
            chk_all($sformatf("idle_strobe%0d", i), 19'h50005, 8'h12, 0, 0);
        end

        foreach (vecs[i]) begin
            cycle(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].stb);
            chk_all($sformatf("vec%0d", i), vecs[i].e_cmp, vecs[i].e_ds,
                    vecs[i].e_dirty, vecs[i].e_busy);
        end

        // Reset asserted mid-ramp, then a commit as from power-up
        cycle(1, 3'd5, 8'h01, 0);
        cycle(1, 3'd0, 8'h30, 0);
        cycle(1, 3'd4, 8'h00, 0);
        cycle(0, 3'd0, 8'h00, 1);
        chk_all("pre_rst_ramp", 19'h00021, 8'hAB, 0, 1);
        @(negedge clk1d);
        rst = 1'b1;
        #1;
        chk_all("rst_async", 19'h50005, 8'h12, 0, 0);
        @(posedge clk1d);
        #1;
        chk_all("rst_next_cycle", 19'h50005, 8'h12, 0, 0);
        @(negedge clk1d);
        rst = 1'b0;
        cycle(1, 3'd4, 8'h00, 0);
        chk_all("post_rst_commit", 19'h50005, 8'h12, 0, 1);
        cycle(0, 3'd0, 8'h00, 1);
        chk_all("post_rst_strobe", 19'h50005, 8'h12, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pwm_setpoint_ctrl.md
PWM_SETPOINT_CTRL -- requirements
Module: pwm_setpoint_ctrl

Interface
REQ-001 The block SHALL have parameter PWMWIDTH, default 19, which is the compare-value width.
REQ-002 The block SHALL have parameter DSBITS, default 8, which is the delta-sigma fraction width.
REQ-003 The block SHALL have port clk1d, input, 1 bit, the PWM system clock.
REQ-004 The block SHALL have port rst, input, 1 bit, reset; asynchronous, active-high.
REQ-005 The block SHALL have port regAddr, input, 3 bits, the register address from the I2C register interface.
REQ-006 The block SHALL have port regData, input, 8 bits, the register write data.
REQ-007 The block SHALL have port regDataValid, input, 1 bit, a single-cycle write strobe.
REQ-008 The block SHALL have port period_strobe, input, 1 bit, a single-cycle pulse at each PWM period start.
REQ-009 The block SHALL have port cmpA, output, PWMWIDTH bits, the compare value driven to the PWM.
REQ-010 The block SHALL have port ds_fraction, output, DSBITS bits, the fraction driven to the PWM.
REQ-011 The block SHALL have port dirty, output, 1 bit, high while the scratch registers differ from the last commit.
REQ-012 The block SHALL have port busy, output, 1 bit, high while a ramp is in progress.

Function
REQ-013 The register map SHALL be: 0 = target[7:0], 1 = target[15:8], 2 = target[PWMWIDTH-1:16] (from regData[2:0], upper bits ignored), 3 = ds scratch, 4 = commit, 5 = step[7:0], 6 = step[15:8], 7 = abort; regData is ignored for addresses 4 and 7.
REQ-014 Each write SHALL take effect in the cycle after regDataValid; a write to address 0-3, 5 or 6 SHALL set dirty.
REQ-015 A commit SHALL copy the scratch target and scratch ds to the active target and pending ds, clear dirty, and enter RAMP.
REQ-016 The state machine SHALL have two states, IDLE and RAMP.
REQ-017 IDLE SHALL go to RAMP on commit; RAMP SHALL go to IDLE when cmpA equals the target after a strobe update, or on abort.
REQ-018 In RAMP, on each period_strobe, cmpA SHALL move toward the target by min(step, |target-cmpA|), with no overshoot.
REQ-019 The difference SHALL be computed in PWMWIDTH+1 bits, and step SHALL be zero-extended.
REQ-020 step == 0 SHALL mean an immediate jump to the target at the next period_strobe.
REQ-021 cmpA and ds_fraction SHALL change only in the cycle after a period_strobe, never mid-period.
REQ-022 ds_fraction SHALL take the pending ds on the same strobe at which cmpA reaches the target.
REQ-023 A commit during RAMP SHALL retarget, continuing from the current cmpA, with no restart or glitch.
REQ-024 When commit and period_strobe occur in the same cycle, the strobe step SHALL use the old target and step, and the new target SHALL be latched that cycle.
REQ-025 When commit occurs in IDLE together with period_strobe, the first step SHALL occur at the following strobe.
REQ-026 Abort SHALL freeze cmpA at its current value, discard the pending ds, go to IDLE, and leave dirty unchanged.
REQ-027 A commit with target equal to cmpA SHALL apply the pending ds at the next strobe, then go to IDLE.
REQ-028 Writes to scratch or step during RAMP SHALL affect only the next commit, except step, which SHALL take effect at the next strobe.
REQ-029 busy SHALL equal (state == RAMP).
REQ-030 The block SHALL use no combinational path from input to output; all outputs SHALL be registered.

Reset
REQ-031 While rst is asserted, the block SHALL set cmpA, the target and the scratch target to 19'h50005 ({16'hA000,3'h5}).
REQ-032 While rst is asserted, the block SHALL set ds_fraction, the pending ds and the ds scratch to 8'h12.
REQ-033 While rst is asserted, step SHALL be 16'h0000, dirty SHALL be 0, busy SHALL be 0, and the state SHALL be IDLE.
REQ-034 Reset mid-ramp SHALL abandon the ramp immediately; the first commit after reset release SHALL behave as from power-up.

Structure
REQ-035 The package pwm_cfg_pkg SHALL hold the PWMWIDTH/DSBITS defaults, the address constants ADDR_TGT0..ADDR_ABORT, the reset values CMPA_RST and DS_RST, and the state enum.
REQ-036 The block SHALL be a single module with no sub-module; the step/clamp arithmetic SHALL be inline.

Verification
REQ-037 Reset release, no writes, 10 strobes -> cmpA 19'h50005, ds_fraction 8'h12, dirty 0, busy 0 throughout.
REQ-038 Write target 19'h50105, step 16'h0040, commit, strobes -> cmpA 50045, 50085, 500C5, 50105, then busy 0; ds applied on the 4th strobe only.
REQ-039 step 0, commit target 19'h00010 -> cmpA 19'h00010 one cycle after the next strobe; no change before the strobe.
REQ-040 Mid-ramp (cmpA 50085), commit target 19'h50000, step 16'h0040 -> cmpA 50045, 50005, 50000; no overshoot.
REQ-041 Commit and period_strobe in the same cycle during a ramp -> that step uses the old target; the next step moves toward the new target.
REQ-042 Abort at cmpA 50085 -> cmpA holds 50085, busy 0, ds_fraction unchanged; rst pulse mid-ramp -> all reset values next cycle.
